// File: rtl/alu_mc_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_mc_if                                                     |
// | Description : Operand/result handshake bundle for the multi-cycle ALU.     |
// |               master : producer/consumer side (drives operands, accepts)   |
// |               slave  : ALU side (accepts operands, presents result)        |
// |               Signals: in_valid/in_ready, a, b, op,                        |
// |                        out_valid/out_ready, out, zero, ovf, err            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             ovf;
    logic             err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, out, zero, ovf, err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, out, zero, ovf, err
    );
endinterface
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_mc                                                        |
// | Description : Multi-cycle ALU. Logic/add/sub/illegal ops finish in one     |
// |               cycle; shifts/rotates step one bit per cycle; optional       |
// |               shift-add multiply takes WIDTH cycles. Result is held in     |
// |               output registers until accepted.                             |
// | Ports       : clk    - rising-edge clock                                   |
// |               rst_n  - asynchronous active-low reset                       |
// |               bus    - alu_mc_if.slave (operands in, result out)           |
// | Options     : ALU_MC_MUL_EN - compile in the MUL state and datapath        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic rst_n,
    alu_mc_if.slave   bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
`ifdef ALU_MC_MUL_EN
    localparam logic [1:0] c_st_mul   = 2'd2;
    localparam logic [3:0] c_op_mul   = 4'b0110;
    localparam logic [SHW:0] c_cnt_width = (SHW+1)'(WIDTH);
`endif
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [3:0] c_op_add = 4'b0000;
    localparam logic [3:0] c_op_sub = 4'b0001;
    localparam logic [3:0] c_op_and = 4'b0010;
    localparam logic [3:0] c_op_or  = 4'b0011;
    localparam logic [3:0] c_op_not = 4'b0100;
    localparam logic [3:0] c_op_sra = 4'b1000;
    localparam logic [3:0] c_op_srl = 4'b1010;
    localparam logic [3:0] c_op_sll = 4'b1001;
    localparam logic [3:0] c_op_rol = 4'b1100;
    localparam logic [3:0] c_op_ror = 4'b1101;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_work;
    logic [SHW:0]     r_cnt;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;
    logic             r_ovf;
    logic             r_err;
`ifdef ALU_MC_MUL_EN
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_nxt;
`endif

    logic             w_accept;
    logic             w_is_shift;
    logic [SHW-1:0]   w_amt;
    logic [WIDTH-1:0] w_bop;
    logic [WIDTH-1:0] w_sum;
    logic             w_add_ovf;
    logic [WIDTH-1:0] w_imm_out;
    logic             w_imm_ovf;
    logic             w_imm_err;
    logic [WIDTH-1:0] w_shift_nxt;

    assign w_accept   = bus.in_valid && (r_state == c_st_idle);
    assign w_amt      = bus.b[SHW-1:0];
    assign w_is_shift = (bus.op == c_op_sra) || (bus.op == c_op_srl) ||
                        (bus.op == c_op_sll) || (bus.op == c_op_rol) ||
                        (bus.op == c_op_ror);

    // Subtraction adds the two's complement of B; overflow compares signs
    // against that effective addend, not against B itself.
    assign w_bop     = (bus.op == c_op_sub) ? (~bus.b + 1'b1) : bus.b;
    assign w_sum     = bus.a + w_bop;
    assign w_add_ovf = (bus.a[WIDTH-1] == w_bop[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != bus.a[WIDTH-1]);

    // Single-cycle results; shift codes land here only with amount 0.
    always_comb begin
        w_imm_out = '0;
        w_imm_ovf = 1'b0;
        w_imm_err = 1'b0;
        case (bus.op)
            c_op_add, c_op_sub: begin
                w_imm_out = w_sum;
                w_imm_ovf = w_add_ovf;
            end
            c_op_and: w_imm_out = bus.a & bus.b;
            c_op_or:  w_imm_out = bus.a | bus.b;
            c_op_not: w_imm_out = ~bus.a;
            c_op_sra, c_op_srl, c_op_sll, c_op_rol, c_op_ror: w_imm_out = bus.a;
            default:  w_imm_err = 1'b1;
        endcase
    end

    // One-bit step of the working register in the captured direction.
    always_comb begin
        w_shift_nxt = r_work;
        case (r_op)
            c_op_sra: w_shift_nxt = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            c_op_srl: w_shift_nxt = {1'b0, r_work[WIDTH-1:1]};
            c_op_sll: w_shift_nxt = {r_work[WIDTH-2:0], 1'b0};
            c_op_rol: w_shift_nxt = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
            c_op_ror: w_shift_nxt = {r_work[0], r_work[WIDTH-1:1]};
            default:  w_shift_nxt = r_work;
        endcase
    end

`ifdef ALU_MC_MUL_EN
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
`ifdef ALU_MC_MUL_EN
                    if (bus.op == c_op_mul) begin
                        w_next = c_st_mul;
                    end else
`endif
                    if (w_is_shift && (w_amt != '0)) begin
                        w_next = c_st_shift;
                    end else begin
                        w_next = c_st_done;
                    end
                end
            end
            c_st_shift: begin
                if (r_cnt == (SHW+1)'(1)) w_next = c_st_done;
            end
`ifdef ALU_MC_MUL_EN
            c_st_mul: begin
                if (r_cnt == (SHW+1)'(1)) w_next = c_st_done;
            end
`endif
            c_st_done: begin
                if (bus.out_ready) w_next = c_st_idle;
            end
            default: w_next = c_st_idle;
        endcase
    end

    // Outputs
    always_comb begin
        bus.in_ready  = (r_state == c_st_idle);
        bus.out_valid = (r_state == c_st_done);
        bus.out       = r_out;
        bus.zero      = r_zero;
        bus.ovf       = r_ovf;
        bus.err       = r_err;
    end

    // Datapath: result registers are written only on the edge entering DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= '0;
            r_work <= '0;
            r_cnt  <= '0;
            r_out  <= '0;
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
            r_err  <= 1'b0;
`ifdef ALU_MC_MUL_EN
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
`endif
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_op   <= bus.op;
                        r_work <= bus.a;
                        if (w_next == c_st_done) begin
                            r_out  <= w_imm_out;
                            r_zero <= (w_imm_out == '0);
                            r_ovf  <= w_imm_ovf;
                            r_err  <= w_imm_err;
                        end
                        if (w_next == c_st_shift) begin
                            r_cnt <= {1'b0, w_amt};
                        end
`ifdef ALU_MC_MUL_EN
                        if (w_next == c_st_mul) begin
                            r_mcand  <= bus.a;
                            r_mplier <= bus.b;
                            r_acc    <= '0;
                            r_cnt    <= c_cnt_width;
                        end
`endif
                    end
                end
                c_st_shift: begin
                    r_work <= w_shift_nxt;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == (SHW+1)'(1)) begin
                        r_out  <= w_shift_nxt;
                        r_zero <= (w_shift_nxt == '0);
                        r_ovf  <= 1'b0;
                        r_err  <= 1'b0;
                    end
                end
`ifdef ALU_MC_MUL_EN
                c_st_mul: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == (SHW+1)'(1)) begin
                        r_out  <= w_acc_nxt;
                        r_zero <= (w_acc_nxt == '0);
                        r_ovf  <= 1'b0;
                        r_err  <= 1'b0;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised ALU for the MIPS datapath, replacing the single-cycle combinational ALU wherever variable-amount shifts/rotates or multiply are needed. Operands enter through a valid/ready handshake. Logic and add/sub results appear one cycle later. Shifts and rotates run iteratively, one bit position per cycle. The optional multiply runs shift-add over WIDTH cycles. Results are held in output registers until the consumer accepts them.

## Interface
- WIDTH, 32: datapath width; power of two, ≥4.
- SHW (localparam), $clog2(WIDTH): shift-amount width.

- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- In_valid  in  1  operands/opcode valid.
- In_ready  out  1  block can accept; high only in IDLE.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; for shifts/rotates only B[SHW-1:0] is used (amount).
- Op  in  4  opcode.
- Out_valid  out  1  result valid; held until accepted.
- Out_ready  in  1  consumer accepts result.
- Out  out  WIDTH  registered result.
- Zero  out  1  Out == 0; meaningful only with Out_valid.
- Ovf  out  1  signed overflow for ADD/SUB; 0 for all other ops.
- Err  out  1  illegal opcode flag.

## Operation
- Handshake:
  - Accept occurs when In_valid && In_ready; A, B and Op are captured.
  - Result transfer occurs when Out_valid && Out_ready.
- Opcodes:
  - 0000 ADD: A+B.
  - 0001 SUB: A−B.
  - 0010 AND.
  - 0011 OR.
  - 0100 NOT: ~A.
  - 1000 SRA: arithmetic right.
  - 1010 SRL: logical right.
  - 1001 SLL: logical left.
  - 1100 ROL: rotate left.
  - 1101 ROR: rotate right.
  - 0110 MUL: low WIDTH bits of A*B, unsigned; only with macro.
  - All other codes: Out=0, Err=1, Zero=1, latency 1.
- Arithmetic: all results truncated to WIDTH; no carry out. Ovf = sign(A)==sign(B') && sign(result)!=sign(A), where B' = B for ADD and ~B+1 for SUB.
- FSM states: IDLE, SHIFT, MUL, DONE.
  - IDLE → DONE on accepting a single-cycle op, or a shift/rotate with amount 0.
  - IDLE → SHIFT on accepting a shift/rotate with amount ≠ 0. The amount is loaded into a down-counter.
  - IDLE → MUL on accepting MUL. The multiplicand, multiplier and accumulator are loaded; the counter is set to WIDTH.
  - SHIFT: each cycle the working register moves one bit in the selected direction and the counter decrements. On the cycle the counter reaches 0, → DONE.
  - MUL: each cycle, if the multiplier LSB=1, add the multiplicand to the accumulator; shift the multiplicand left and the multiplier right; decrement the counter. On the cycle the counter reaches 0, → DONE.
  - DONE: Out_valid=1; → IDLE on Out_ready.
- Out, Zero, Ovf and Err are written only on entry to DONE and are stable throughout DONE.

## Timing
- Reset values: state=IDLE, In_ready=1, Out_valid=0, Out=0, Zero=0, Ovf=0, Err=0, counter=0.
- Latency, measured from the accept edge to Out_valid high:
  - ADD/SUB/AND/OR/NOT, illegal ops, and shifts with amount 0: 1 cycle.
  - Shift/rotate by n: n+1 cycles.
  - MUL: WIDTH+1 cycles.
- In_ready is low from the accept edge until the edge after result transfer. There is no same-cycle accept on transfer, so the minimum initiation interval is 2 cycles.
- Out_ready asserted while Out_valid=0 has no effect. Out_valid stays high indefinitely while Out_ready=0.
- In_valid while In_ready=0 is ignored; operands are not sampled.
- Reset_n low mid-operation: the next state is reset immediately (asynchronously), the in-flight op is discarded, and no Out_valid is produced.
- Amount = WIDTH−1 is the maximum, giving latency WIDTH cycles. Rotates wrap bit 0 ↔ bit WIDTH−1 each step.

## Configuration
- ALU_MC_MUL_EN defined:
  - The MUL state and shift-add datapath are compiled in.
  - Op 0110 performs the multiply.
- Not defined:
  - The MUL state and datapath are absent.
  - Op 0110 is treated as illegal: Err=1, Out=0, latency 1.

## Test plan
- Reset, then ADD A=0x7FFFFFFF, B=1 accepted, Out_ready=1 → after 1 cycle: Out=0x80000000, Ovf=1, Zero=0. In_ready returns to 1 one cycle after transfer.
- SUB A=5, B=5 → Out=0, Zero=1, Ovf=0. NOT A=0 → Out=0xFFFFFFFF.
- SRA A=0x80000000, B=31 → Out_valid exactly 32 cycles after accept, Out=0xFFFFFFFF. SRL with the same operands → Out=0x00000001.
- ROR A=0x00000001, B=1 → Out=0x80000000 after 2 cycles. ROL amount 0 → Out=A after 1 cycle. Out_ready held low 5 cycles → Out held stable and In_ready=0 throughout.
- With ALU_MC_MUL_EN: MUL A=0xFFFF, B=0x10001 → Out=0xFFFFFFFF after 33 cycles. Without the macro: Op=0110 → Err=1, Out=0 after 1 cycle.
- Start SLL by 20 and drop Reset_n at cycle 5 → Out_valid=0, In_ready=1 and Out=0 immediately. The next ADD 2+3 → Out=5.
